pop_counter_bank: RTL and testbench
===================================

# pop_counter_bank

Parametrised bank of per-channel pop counters that tallies words leaving each output FIFO of the switch and serves single-entry readout to the test bench through a req/ack handshake. It generalises the fixed 4-channel, 5-bit counter to NUM_CH channels of CNT_W bits, with selectable wrap/saturate mode, sticky overflow flags, optional clear-on-read and an out-of-range index error. It sits beside the FIFO bank, driven by the FIFO pop strobes and the top-level IDLE indication.

## Interface
- NUM_CH, 4, number of counted channels (≥2)
- CNT_W, 5, counter width in bits
- SAT_MODE, 0, 0 = wrap at 2^CNT_W, 1 = saturate at 2^CNT_W−1
- CLR_ON_RD, 0, 1 = accepted read clears the selected counter and its overflow flag
- IDX_W, $clog2(NUM_CH), width of idx

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pop  in  NUM_CH  per-channel pop strobe, one word per cycle high
- idle  in  1  system in IDLE; gates read acceptance only
- req  in  1  read request
- idx  in  IDX_W  channel to read
- rd_ack  in  1  consumer accepts the held response
- rd_valid  out  1  response valid, held until acked
- rd_data  out  CNT_W  sampled count
- rd_ovf  out  1  sampled overflow flag of the channel
- rd_err  out  1  idx ≥ NUM_CH

## Operation
- Counting is always active, independent of idle and read state; all channels count concurrently.
- pop[i]=1 at an edge: cnt[i] increments by 1.
- Wrap mode: cnt = 2^CNT_W−1 plus pop → 0, ovf[i] ← 1.
- Saturate mode: cnt = 2^CNT_W−1 plus pop → holds, ovf[i] ← 1.
- ovf[i] is sticky; cleared only by reset or clear-on-read.
- Read FSM, two states: S_IDLE, S_RESP.
- S_IDLE → S_RESP when req=1 and idle=1 at an edge. On that edge: rd_data ← cnt[idx], rd_ovf ← ovf[idx] (pre-increment values of that edge), rd_err ← 0, rd_valid ← 1.
- Out-of-range idx (only possible when NUM_CH is not a power of 2): rd_data ← 0, rd_ovf ← 0, rd_err ← 1, rd_valid ← 1; no counter affected.
- CLR_ON_RD=1 with in-range idx: at the accepting edge cnt[idx] ← pop[idx] (0 or 1), ovf[idx] ← 0. No pop is lost.
- S_RESP → S_IDLE when rd_ack=1 at an edge; rd_valid, rd_err → 0. rd_data and rd_ovf hold their last value.
- req is ignored in S_RESP; idle falling during S_RESP does not abort the response.
- rd_ack in S_IDLE is ignored.

## Timing
- Reset (edge with reset=1): all cnt, ovf → 0; FSM → S_IDLE; rd_valid, rd_data, rd_ovf, rd_err → 0. Applies mid-response: the pending response is dropped.
- Pop to counter update: 1 cycle.
- Request to rd_valid: 1 cycle (registered outputs).
- rd_valid minimum high time 1 cycle; ack in the first valid cycle returns to S_IDLE on that edge.
- Back-to-back reads: the next request is accepted at the edge after the ack edge, giving one cycle of rd_valid=0 between responses.
- Simultaneous pop and read of the same channel: the response carries the old value; the counter shows old+1 (no clear) or 1 (clear-on-read).

## Structure
- Shared package pop_counter_pkg: FSM state enum (S_IDLE, S_RESP), mode localparams MODE_WRAP/MODE_SAT.
- Sub-module pop_cnt_cell (one per channel, generate loop): CNT_W counter with inc, clr, SAT_MODE, and sticky ovf. Top level contains the read FSM, idx mux and range check.

## Test plan
- Reset, then 7 pops on ch2, req idx=2 idle=1 → next cycle rd_valid=1, rd_data=7, rd_ovf=0; held until rd_ack.
- SAT_MODE=0: 33 pops on ch0 → read returns rd_data=1, rd_ovf=1. SAT_MODE=1: same stimulus → 31, rd_ovf=1.
- CLR_ON_RD=1: 5 pops on ch1, read ch1 with pop[1]=1 on the accept edge → rd_data=5; the next read returns 1, rd_ovf=0.
- req with idle=0 → no response; req held during S_RESP → ignored until ack; a second read of ch3 after ack returns the correct value with a 1-cycle rd_valid gap.
- NUM_CH=3, idx=3 → rd_valid=1, rd_err=1, rd_data=0; counters unchanged.
- reset asserted while rd_valid=1 and counters nonzero → all outputs 0 and a later read returns 0.

Source files
------------

// File: rtl/pop_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pop_counter_pkg
//  Description : Shared types and constants for the pop counter bank: read
//                FSM state encoding and counter overflow-mode selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package pop_counter_pkg;

    // Read FSM state encoding (one bit is enough for two states)
    typedef logic [0:0] state_t;

    localparam state_t S_IDLE = 1'b0;   // waiting for an accepted request
    localparam state_t S_RESP = 1'b1;   // response held until acknowledged

    // Counter overflow behaviour
    localparam int MODE_WRAP = 0;       // roll over to zero
    localparam int MODE_SAT  = 1;       // stick at all-ones

endpackage : pop_counter_pkg
`default_nettype wire

// File: rtl/pop_cnt_cell.sv
`default_nettype none
// ============================================================================
//  Module      : pop_cnt_cell
//  Description : Single-channel pop counter. Increments once per inc cycle,
//                wraps or saturates at all-ones and records a sticky overflow
//                flag. A clear reloads the counter with the same-cycle inc so
//                a pop coinciding with a clear is never lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module pop_cnt_cell
    import pop_counter_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] c_max    = '1;
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic             c_sat_en = (SAT_MODE == MODE_SAT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_at_max;

    assign w_at_max = (r_cnt == c_max);

    // Counter and sticky overflow update; clear takes priority but keeps the pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= inc ? c_one : '0;
            r_ovf <= 1'b0;
        end else if (inc) begin
            if (w_at_max) begin
                r_ovf <= 1'b1;
                r_cnt <= c_sat_en ? c_max : '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;

endmodule : pop_cnt_cell
`default_nettype wire

// File: rtl/pop_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pop_counter_bank
//  Description : Bank of NUM_CH per-channel pop counters with a single-entry
//                req/ack readout port. Counting never stalls; reads are only
//                accepted while the system is idle. Out-of-range indices
//                return an error response without touching any counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pop_counter_bank
    import pop_counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 5,
    parameter int SAT_MODE  = MODE_WRAP,
    parameter int CLR_ON_RD = 0,
    parameter int IDX_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pop,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              rd_ack,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              rd_err
);

    localparam logic [IDX_W:0] c_num_ch = NUM_CH[IDX_W:0];
    localparam logic           c_clr_en = (CLR_ON_RD != 0);

    // Per-channel counter state
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_clr;

    // Read path
    logic             w_idx_ok;
    logic             w_accept;
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_sel_ovf;

    // Read FSM and registered response
    state_t           r_state;
    logic             r_valid;
    logic [CNT_W-1:0] r_data;
    logic             r_ovf;
    logic             r_err;

    // ------------------------------------------------------------------------
    // Counter cells, one per channel
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Clear-on-read only hits the channel being read by an accepted request
            assign w_clr[gi] = c_clr_en && w_accept && w_idx_ok && (idx == IDX_W'(gi));

            pop_cnt_cell #(
                .CNT_W    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .inc   (pop[gi]),
                .clr   (w_clr[gi]),
                .cnt   (w_cnt[gi]),
                .ovf   (w_ovf[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Index range check and accept condition
    // ------------------------------------------------------------------------
    assign w_idx_ok = ({1'b0, idx} < c_num_ch);
    assign w_accept = (r_state == S_IDLE) && req && idle;

    // Select the addressed channel; unmatched (out-of-range) indices yield zero
    always_comb begin
        w_sel_cnt = '0;
        w_sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                w_sel_cnt = w_cnt[i];
                w_sel_ovf = w_ovf[i];
            end
        end
    end

    // Read FSM: capture the selected channel on accept, hold until acknowledged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_state <= S_RESP;
                r_valid <= 1'b1;
                if (w_idx_ok) begin
                    r_data <= w_sel_cnt;
                    r_ovf  <= w_sel_ovf;
                    r_err  <= 1'b0;
                end else begin
                    r_data <= '0;
                    r_ovf  <= 1'b0;
                    r_err  <= 1'b1;
                end
            end
        end else begin
            // Response data and overflow stay visible after the ack
            if (rd_ack) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_ovf   = r_ovf;
    assign rd_err   = r_err;

endmodule : pop_counter_bank
`default_nettype wire

// File: tb/tb_pop_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pop_counter_bank
//  Description : Self-checking bench. Two instances share one stimulus stream:
//                A = 4 channels, wrap, no clear-on-read;
//                B = 3 channels, saturate, clear-on-read (idx 3 is out of range).
//                A behavioural model predicts every response each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_counter_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pop;
    logic       idle;
    logic       req;
    logic [1:0] idx;
    logic       rd_ack;

    logic       a_valid, a_ovf, a_err;
    logic [4:0] a_data;
    logic       b_valid, b_ovf, b_err;
    logic [4:0] b_data;

    int total  = 0;
    int passed = 0;

    // Behavioural model state, index 0 = instance A, 1 = instance B
    int num_ch [2] = '{4, 3};
    bit sat    [2] = '{1'b0, 1'b1};
    bit clr    [2] = '{1'b0, 1'b1};
    int m_cnt  [2][4];
    bit m_ovf  [2][4];
    bit m_busy [2];
    int m_data [2];
    bit m_rovf [2];
    bit m_err  [2];

    always #5 clk = ~clk;

    pop_counter_bank #(
        .NUM_CH    (4),
        .CNT_W     (5),
        .SAT_MODE  (0),
        .CLR_ON_RD (0)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .pop      (pop),
        .idle     (idle),
        .req      (req),
        .idx      (idx),
        .rd_ack   (rd_ack),
        .rd_valid (a_valid),
        .rd_data  (a_data),
        .rd_ovf   (a_ovf),
        .rd_err   (a_err)
    );

    pop_counter_bank #(
        .NUM_CH    (3),
        .CNT_W     (5),
        .SAT_MODE  (1),
        .CLR_ON_RD (1)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .pop      (pop[2:0]),
        .idle     (idle),
        .req      (req),
        .idx      (idx),
        .rd_ack   (rd_ack),
        .rd_valid (b_valid),
        .rd_data  (b_data),
        .rd_ovf   (b_ovf),
        .rd_err   (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    endtask

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int ch = 0; ch < 4; ch++) begin
                    m_cnt[c][ch] = 0;
                    m_ovf[c][ch] = 1'b0;
                end
                m_busy[c] = 1'b0;
                m_data[c] = 0;
                m_rovf[c] = 1'b0;
                m_err[c]  = 1'b0;
            end else begin
                if (!m_busy[c] && req && idle) begin
                    m_busy[c] = 1'b1;
                    if (int'(idx) < num_ch[c]) begin
                        m_data[c] = m_cnt[c][idx];
                        m_rovf[c] = m_ovf[c][idx];
                        m_err[c]  = 1'b0;
                        if (clr[c]) begin
                            m_cnt[c][idx] = 0;
                            m_ovf[c][idx] = 1'b0;
                        end
                    end else begin
                        m_data[c] = 0;
                        m_rovf[c] = 1'b0;
                        m_err[c]  = 1'b1;
                    end
                end else if (m_busy[c] && rd_ack) begin
                    m_busy[c] = 1'b0;
                    m_err[c]  = 1'b0;
                end
                for (int ch = 0; ch < num_ch[c]; ch++) begin
                    if (pop[ch]) begin
                        if (m_cnt[c][ch] == 31) begin
                            m_ovf[c][ch] = 1'b1;
                            m_cnt[c][ch] = sat[c] ? 31 : 0;
                        end else begin
                            m_cnt[c][ch] = m_cnt[c][ch] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: update model at the edge, compare all outputs shortly after
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("A.rd_valid", a_valid, m_busy[0]);
        chk("A.rd_data",  a_data,  m_data[0]);
        chk("A.rd_ovf",   a_ovf,   m_rovf[0]);
        chk("A.rd_err",   a_err,   m_err[0]);
        chk("B.rd_valid", b_valid, m_busy[1]);
        chk("B.rd_data",  b_data,  m_data[1]);
        chk("B.rd_ovf",   b_ovf,   m_rovf[1]);
        chk("B.rd_err",   b_err,   m_err[1]);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; pop = '0; idle = 1'b1; req = 1'b0; idx = '0; rd_ack = 1'b0;
        ticks(2);
        chk("reset.valid", a_valid, 0);
        reset = 1'b0;

        // Seven pops on channel 2, then read it and hold without ack
        pop = 4'b0100;
        ticks(7);
        pop = '0; req = 1'b1; idx = 2'd2;
        tick();
        chk("ch2.valid", a_valid, 1);
        chk("ch2.data7", a_data, 7);
        chk("ch2.ovf0",  a_ovf, 0);
        req = 1'b0;
        ticks(3);
        chk("ch2.held", b_valid, 1);
        rd_ack = 1'b1;
        tick();
        chk("ch2.acked", a_valid, 0);
        rd_ack = 1'b0;

        // 33 pops on channel 0: wrap gives 1, saturate gives 31, both overflowed
        pop = 4'b0001;
        ticks(33);
        pop = '0; req = 1'b1; idx = 2'd0;
        tick();
        chk("wrap.data", a_data, 1);
        chk("wrap.ovf",  a_ovf, 1);
        chk("sat.data",  b_data, 31);
        chk("sat.ovf",   b_ovf, 1);
        req = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;

        // Clear-on-read with a pop on the accepting edge
        pop = 4'b0010;
        ticks(5);
        req = 1'b1; idx = 2'd1;
        tick();
        chk("cor.first", b_data, 5);
        pop = '0; req = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0; req = 1'b1;
        tick();
        chk("cor.second", b_data, 1);
        chk("cor.ovf",    b_ovf, 0);
        chk("nocor.data", a_data, 6);
        req = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;

        // Request while not idle is not accepted
        idle = 1'b0; req = 1'b1; idx = 2'd0;
        ticks(3);
        chk("notidle", a_valid, 0);
        pop = 4'b1000;
        ticks(4);
        pop = '0;

        // Held request: out-of-range on B, back-to-back with a one-cycle gap
        idle = 1'b1; idx = 2'd3;
        tick();
        chk("ch3.data",  a_data, 4);
        chk("oor.err",   b_err, 1);
        chk("oor.data",  b_data, 0);
        idle = 1'b0;
        ticks(2);
        idle = 1'b1; rd_ack = 1'b1;
        tick();
        chk("gap.valid", a_valid, 0);
        rd_ack = 1'b0;
        tick();
        chk("again.valid", a_valid, 1);
        chk("again.data",  a_data, 4);
        req = 1'b0;

        // Reset during a pending response with nonzero counters
        reset = 1'b1;
        tick();
        chk("rst.valid", a_valid, 0);
        reset = 1'b0; req = 1'b1; idx = 2'd2;
        tick();
        chk("rst.data", a_data, 0);
        req = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            pop    = 4'($urandom);
            req    = ($urandom_range(0, 2) != 0);
            idle   = ($urandom_range(0, 3) != 0);
            idx    = 2'($urandom);
            rd_ack = ($urandom_range(0, 1) != 0);
            reset  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pop_counter_bank
`default_nettype wire
